// File: rtl/seek_to_cylinder.sv
// seek_to_cylinder: head-positioner emulation for a moving-head disk drive.
// A falling edge on the (asynchronous) access-go line starts a seek. The
// cylinder address moves by one or two cylinders, clamped to 0..MAX_CYL,
// and the drive then reports busy for SETTLE_US microseconds.
module seek_to_cylinder #(
    parameter int SETTLE_US = 10000,
    parameter int MAX_CYL   = 202
) (
    input  logic       clkenbl_1usec,
    input  logic       reset,
    input  logic       Selected_Ready,
    input  logic       BUS_ACC_GO_L,
    input  logic       BUS_ACC_REV_L,
    input  logic       BUS_10_20_L,
    input  logic       clkenbl_sector,
    output logic [7:0] Cylinder_Address,
    output logic       BUS_ACCESS_RDY_EMUL_H,
    output logic       BUS_HOME_DRIVE_EMUL_L,
    output logic       oncylinder_indicator,
    output logic       strobe_selected_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        SEEK = 1'b1
    } state_t;

    localparam logic [8:0]  MAX_ADDR    = 9'(MAX_CYL);
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_US - 1);

    state_t      state;
    state_t      state_next;
    logic [1:0]  go_sync;
    logic [1:0]  rev_sync;
    logic [1:0]  step_sync;
    logic        go_prev;
    logic        go_fall;
    logic        seek_start;
    logic [15:0] settle_cnt;
    logic [1:0]  step_size;
    logic [8:0]  fwd_sum;
    logic [7:0]  target_addr;

    // The sector pulse has no function here; it is kept on the port list
    // so the block drops into the existing drive top level unchanged.
    logic unused_sector;
    assign unused_sector = clkenbl_sector;

    // Two-flop synchronizers for the bus lines plus a delayed copy of GO for
    // edge detection; all idle high so reset never looks like a request.
    always_ff @(posedge clkenbl_1usec or negedge reset) begin
        if (!reset) begin
            go_sync   <= 2'b11;
            rev_sync  <= 2'b11;
            step_sync <= 2'b11;
            go_prev   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, which is what turns this into a real shift chain.
            go_sync   <= {go_sync[0], BUS_ACC_GO_L};
            rev_sync  <= {rev_sync[0], BUS_ACC_REV_L};
            step_sync <= {step_sync[0], BUS_10_20_L};
            go_prev   <= go_sync[1];
        end
    end

    assign go_fall    = go_prev & ~go_sync[1];
    assign seek_start = (state == IDLE) && Selected_Ready && go_fall;

    // Target cylinder for a seek starting now: step 1 or 2, clamped at both ends.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and a latch can never be inferred.
        step_size   = step_sync[1] ? 2'd2 : 2'd1;
        fwd_sum     = {1'b0, Cylinder_Address} + {7'd0, step_size};
        target_addr = Cylinder_Address;
        if (!rev_sync[1]) begin
            if ({1'b0, Cylinder_Address} < {7'd0, step_size}) begin
                target_addr = 8'd0;
            end else begin
                target_addr = Cylinder_Address - {6'd0, step_size};
            end
        end else begin
            if (fwd_sum > MAX_ADDR) begin
                target_addr = MAX_ADDR[7:0];
            end else begin
                target_addr = fwd_sum[7:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clkenbl_1usec or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a seek is always timed to completion once started.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (seek_start) state_next = SEEK;
            SEEK: if (settle_cnt == 16'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Settle timer, cylinder register and completion strobe.
    always_ff @(posedge clkenbl_1usec or negedge reset) begin
        if (!reset) begin
            settle_cnt            <= 16'd0;
            Cylinder_Address      <= 8'd0;
            strobe_selected_ready <= 1'b0;
        end else begin
            if (seek_start) begin
                settle_cnt       <= SETTLE_LOAD;
                Cylinder_Address <= target_addr;
            end else if (state == SEEK && settle_cnt != 16'd0) begin
                settle_cnt <= settle_cnt - 16'd1;
            end
            strobe_selected_ready <= (state == SEEK) && (state_next == IDLE)
                                     && Selected_Ready;
        end
    end

    // Status outputs; Selected_Ready gates ready with no register delay.
    always_comb begin
        BUS_ACCESS_RDY_EMUL_H = (state == IDLE) && Selected_Ready;
        BUS_HOME_DRIVE_EMUL_L = ~(BUS_ACCESS_RDY_EMUL_H && (Cylinder_Address == 8'd0));
        oncylinder_indicator  = BUS_ACCESS_RDY_EMUL_H;
    end

endmodule

// File: tb/tb_seek_to_cylinder.sv
// Testbench for seek_to_cylinder: table-driven seeks, hand-written corner
// sequences and randomized seeks against an arithmetic address model.
`timescale 1ns/1ps
module tb_seek_to_cylinder;

    localparam int SETTLE  = 16;
    localparam int MAX_CYL = 202;
    localparam int BUDGET  = SETTLE + 40;
    localparam int LAT     = 2;   // GO sample edges until the first busy sample

    logic       clk;
    logic       rst_n;
    logic       sel;
    logic       go_l;
    logic       rev_l;
    logic       step_l;
    logic       sector;
    logic [7:0] addr;
    logic       rdy;
    logic       home_l;
    logic       onc;
    logic       strobe;

    int checks   = 0;
    int failures = 0;
    int model_addr;

    typedef struct {
        bit rev;
        bit two;
        int exp_addr;
    } vec_t;

    vec_t tab_a[5];
    vec_t tab_b[3];

    seek_to_cylinder #(.SETTLE_US(SETTLE), .MAX_CYL(MAX_CYL)) dut (
        .clkenbl_1usec        (clk),
        .reset                (rst_n),
        .Selected_Ready       (sel),
        .BUS_ACC_GO_L         (go_l),
        .BUS_ACC_REV_L        (rev_l),
        .BUS_10_20_L          (step_l),
        .clkenbl_sector       (sector),
        .Cylinder_Address     (addr),
        .BUS_ACCESS_RDY_EMUL_H(rdy),
        .BUS_HOME_DRIVE_EMUL_L(home_l),
        .oncylinder_indicator (onc),
        .strobe_selected_ready(strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        sector = 1'b0;
        forever begin
            repeat (7) @(negedge clk);
            sector = 1'b1;
            @(negedge clk);
            sector = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Address after one seek, straight from the rules: move, then clamp.
    function automatic int model_next(input int a, input bit rev, input bit two);
        int step;
        int n;
        step = two ? 2 : 1;
        n = rev ? a - step : a + step;
        if (n < 0) n = 0;
        if (n > MAX_CYL) n = MAX_CYL;
        return n;
    endfunction

    // Issue one GO pulse and watch the outputs for a fixed window.
    // Cycle indices count negedge samples after GO was driven low.
    task automatic run_go(input bit rev, input bit two, input int hold,
                          input int pulse2_at, input int sel_off_at, input int sel_on_at,
                          output int low_cycles, output int strobes,
                          output int strobe_cyc, output int rise_cyc);
        bit was_low;
        @(negedge clk);
        rev_l  = ~rev;
        step_l = two;
        repeat (3) @(negedge clk);
        go_l       = 1'b0;
        low_cycles = 0;
        strobes    = 0;
        strobe_cyc = -1;
        rise_cyc   = -1;
        was_low    = 1'b0;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            @(negedge clk);
            if (!rdy) begin
                low_cycles++;
                was_low = 1'b1;
            end else if (was_low && rise_cyc < 0) begin
                rise_cyc = cyc;
            end
            if (strobe) begin
                strobes++;
                if (strobe_cyc < 0) strobe_cyc = cyc;
            end
            if (cyc == hold - 1) go_l = 1'b1;
            if (cyc == pulse2_at) go_l = 1'b0;
            if (cyc == pulse2_at + 3) go_l = 1'b1;
            if (cyc == sel_off_at) sel = 1'b0;
            if (cyc == sel_on_at) sel = 1'b1;
        end
    endtask

    // A normal seek with Selected_Ready high throughout.
    task automatic seek_and_check(input string name, input bit rev, input bit two,
                                  input int hold, input int exp_addr);
        int low, strobes, s_cyc, r_cyc;
        run_go(rev, two, hold, -10, -1, -1, low, strobes, s_cyc, r_cyc);
        check({name, " addr"}, 32'(addr), 32'(exp_addr));
        check({name, " busy_cycles"}, 32'(low), 32'(SETTLE));
        check({name, " strobes"}, 32'(strobes), 32'd1);
        check({name, " ready_return_cycle"}, 32'(r_cyc), 32'(LAT + SETTLE));
        check({name, " strobe_cycle"}, 32'(s_cyc), 32'(LAT + SETTLE));
        check({name, " home_l"}, 32'(home_l), (exp_addr == 0) ? 32'd0 : 32'd1);
        check({name, " oncyl"}, 32'(onc), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_addr = 0;
    endtask

    initial begin
        int low, strobes, s_cyc, r_cyc;
        bit rv, tw;

        tab_a[0] = '{rev: 1'b0, two: 1'b1, exp_addr: 2};
        tab_a[1] = '{rev: 1'b0, two: 1'b0, exp_addr: 3};
        tab_a[2] = '{rev: 1'b1, two: 1'b1, exp_addr: 1};
        tab_a[3] = '{rev: 1'b1, two: 1'b1, exp_addr: 0};
        tab_a[4] = '{rev: 1'b1, two: 1'b0, exp_addr: 0};
        tab_b[0] = '{rev: 1'b1, two: 1'b0, exp_addr: 201};
        tab_b[1] = '{rev: 1'b0, two: 1'b0, exp_addr: 202};
        tab_b[2] = '{rev: 1'b0, two: 1'b0, exp_addr: 202};

        sel    = 1'b1;
        go_l   = 1'b1;
        rev_l  = 1'b1;
        step_l = 1'b1;
        rst_n  = 1'b0;
        #12;
        check("reset addr", 32'(addr), 32'd0);
        check("reset strobe", 32'(strobe), 32'd0);
        check("reset ready", 32'(rdy), 32'd1);
        check("reset home_l", 32'(home_l), 32'd0);
        check("reset oncyl", 32'(onc), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        model_addr = 0;

        // Basic stepping, clamping at zero, null seek at zero
        for (int i = 0; i < 5; i++) begin
            seek_and_check($sformatf("tab_a[%0d]", i), tab_a[i].rev, tab_a[i].two, 3,
                           tab_a[i].exp_addr);
        end
        model_addr = 0;

        // Second GO while seeking is ignored
        run_go(1'b0, 1'b0, 3, 6, -1, -1, low, strobes, s_cyc, r_cyc);
        check("go2 addr", 32'(addr), 32'd1);
        check("go2 busy_cycles", 32'(low), 32'(SETTLE));
        check("go2 strobes", 32'(strobes), 32'd1);

        // GO while not Selected_Ready: no seek, nothing queued
        @(negedge clk);
        sel = 1'b0;
        @(negedge clk);
        check("nosel ready", 32'(rdy), 32'd0);
        run_go(1'b0, 1'b1, 3, -10, -1, 30, low, strobes, s_cyc, r_cyc);
        check("nosel addr", 32'(addr), 32'd1);
        check("nosel low_cycles", 32'(low), 32'd31);
        check("nosel strobes", 32'(strobes), 32'd0);

        // Selected_Ready drops mid-seek: seek completes, no strobe
        run_go(1'b0, 1'b0, 2, -10, 6, 36, low, strobes, s_cyc, r_cyc);
        check("seldrop addr", 32'(addr), 32'd2);
        check("seldrop strobes", 32'(strobes), 32'd0);
        check("seldrop ready_return_cycle", 32'(r_cyc), 32'd37);

        // Reset asserted mid-seek
        @(negedge clk);
        rev_l  = 1'b1;
        step_l = 1'b1;
        repeat (3) @(negedge clk);
        go_l = 1'b0;
        repeat (3) @(negedge clk);
        go_l = 1'b1;
        repeat (4) @(negedge clk);
        check("midreset busy_before", 32'(rdy), 32'd0);
        check("midreset addr_before", 32'(addr), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        check("midreset addr", 32'(addr), 32'd0);
        check("midreset ready", 32'(rdy), 32'd1);
        check("midreset home_l", 32'(home_l), 32'd0);
        check("midreset strobe", 32'(strobe), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        strobes = 0;
        low = 0;
        for (int cyc = 0; cyc < SETTLE + 10; cyc++) begin
            @(negedge clk);
            if (strobe) strobes++;
            if (!rdy) low++;
        end
        check("midreset later_strobes", 32'(strobes), 32'd0);
        check("midreset later_busy", 32'(low), 32'd0);
        model_addr = 0;

        // Randomized seeks against the address model
        for (int i = 0; i < 25; i++) begin
            rv = 1'($urandom_range(0, 1));
            tw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                sel = 1'b0;
                run_go(rv, tw, 3, -10, -1, 30, low, strobes, s_cyc, r_cyc);
                check($sformatf("rand[%0d] nosel addr", i), 32'(addr), 32'(model_addr));
                check($sformatf("rand[%0d] nosel strobes", i), 32'(strobes), 32'd0);
            end else begin
                model_addr = model_next(model_addr, rv, tw);
                seek_and_check($sformatf("rand[%0d]", i), rv, tw,
                               int'($urandom_range(2, 4)), model_addr);
            end
        end

        // Saturation at MAX_CYL
        do_reset();
        for (int i = 0; i < 102; i++) begin
            run_go(1'b0, 1'b1, 2, -10, -1, -1, low, strobes, s_cyc, r_cyc);
            model_addr = model_next(model_addr, 1'b0, 1'b1);
            check($sformatf("sat[%0d] addr", i), 32'(addr), 32'(model_addr));
            check($sformatf("sat[%0d] strobes", i), 32'(strobes), 32'd1);
        end
        check("sat final addr", 32'(addr), 32'd202);
        for (int i = 0; i < 3; i++) begin
            seek_and_check($sformatf("tab_b[%0d]", i), tab_b[i].rev, tab_b[i].two, 2,
                           tab_b[i].exp_addr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seek_to_cylinder.md
SEEK_TO_CYLINDER -- requirements
Module: seek_to_cylinder

Interface
REQ-001 SHALL have parameter SETTLE_US, default 10000, seek busy time in clkenbl_1usec cycles.
REQ-002 SHALL have parameter MAX_CYL, default 202, highest legal cylinder.
REQ-003 SHALL have port clkenbl_1usec  input  1  clock (1 MHz); all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Selected_Ready  input  1  drive selected and ready, active high.
REQ-006 SHALL have port BUS_ACC_GO_L  input  1  access go (seek request), active low, asynchronous.
REQ-007 SHALL have port BUS_ACC_REV_L  input  1  direction: low = reverse (toward 0), high = forward.
REQ-008 SHALL have port BUS_10_20_L  input  1  step size: low = 1 cylinder, high = 2 cylinders.
REQ-009 SHALL have port clkenbl_sector  input  1  sector enable pulse; reserved, no functional effect.
REQ-010 SHALL have port Cylinder_Address  output  8  current cylinder, 0..MAX_CYL.
REQ-011 SHALL have port BUS_ACCESS_RDY_EMUL_H  output  1  access ready, active high.
REQ-012 SHALL have port BUS_HOME_DRIVE_EMUL_L  output  1  at home cylinder, active low.
REQ-013 SHALL have port oncylinder_indicator  output  1  front-panel On Cylinder lamp, active high.
REQ-014 SHALL have port strobe_selected_ready  output  1  one-cycle seek-complete strobe.

Function
REQ-015 SHALL synchronize BUS_ACC_GO_L, BUS_ACC_REV_L, BUS_10_20_L through two flops each before use.
REQ-016 SHALL detect a GO request as a high-to-low transition of synchronized BUS_ACC_GO_L; a low pulse must last at least 2 cycles to be detected.
REQ-017 SHALL use two states, IDLE and SEEK; reset enters IDLE.
REQ-018 In IDLE with Selected_Ready high, a GO request SHALL enter SEEK on the next cycle and latch synchronized REV and 10_20 at that edge.
REQ-019 GO requests while Selected_Ready is low or while in SEEK SHALL be ignored (not queued).
REQ-020 On SEEK entry, Cylinder_Address SHALL update in the same cycle: forward adds step, clamped to MAX_CYL; reverse subtracts step, clamped to 0 (no wrap).
REQ-021 A seek that does not change the address (reverse at 0, forward at MAX_CYL) SHALL still run the full SEEK timing.
REQ-022 SEEK SHALL last exactly SETTLE_US cycles via a 16-bit down counter, then return to IDLE.
REQ-023 BUS_ACCESS_RDY_EMUL_H SHALL be high only when state is IDLE and Selected_Ready is high (Selected_Ready applied combinationally).
REQ-024 BUS_HOME_DRIVE_EMUL_L SHALL be low only when Cylinder_Address is 0 and BUS_ACCESS_RDY_EMUL_H is high; otherwise high.
REQ-025 oncylinder_indicator SHALL equal BUS_ACCESS_RDY_EMUL_H.
REQ-026 strobe_selected_ready SHALL pulse high for exactly one cycle on the cycle the state returns SEEK to IDLE while Selected_Ready is high; otherwise low.
REQ-027 If Selected_Ready drops during SEEK, the seek SHALL complete normally (address kept, timer runs); ready stays low until Selected_Ready returns.

Reset
REQ-028 Asserting reset SHALL, asynchronously and also mid-seek: state IDLE, counter 0, Cylinder_Address 0, strobe_selected_ready 0, synchronizers to 1 (idle high).
REQ-029 After reset with Selected_Ready high: BUS_ACCESS_RDY_EMUL_H 1, BUS_HOME_DRIVE_EMUL_L 0, oncylinder_indicator 1.

Verification
REQ-030 From 0, GO pulse 3 us with REV_L=1, 10_20_L=1 -> address 2, ready low SETTLE_US cycles, HOME_L 1, one strobe at completion.
REQ-031 From 2: forward step 1 -> 3; reverse step 2 -> 1; reverse step 2 -> 0 (clamped), HOME_L returns 0 after settle.
REQ-032 At 0, reverse step 1 -> address stays 0, ready still low SETTLE_US cycles, then strobe, HOME_L 0.
REQ-033 102 forward 2-cylinder steps from 0 -> address saturates at 202; reverse 1 -> 201; forward 1 -> 202; forward 1 -> stays 202.
REQ-034 Second GO during SEEK -> ignored, single address change; Selected_Ready low with GO -> no seek, ready low.
REQ-035 Reset asserted mid-seek -> address 0, IDLE, ready high immediately (Selected_Ready high), no strobe.
